sfx_scheduler: RTL and testbench

SFX_SCHEDULER -- requirements
Module: sfx_scheduler

---
 rtl/sfx_scheduler.sv | 156 +++++++++++++++
 tb/tb_sfx_scheduler.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/sfx_scheduler.sv
// Sound-effect sequencer: steps through a fixed per-effect table of
// (half_period, tone, duration_ms) entries, with priority preemption.
module sfx_scheduler #(
  parameter int TICK_DIV = 50000
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic        mute,
  output logic [18:0] half_period,
  output logic        tone_on,
  output logic        busy,
  output logic [1:0]  active_id,
  output logic [2:0]  ack
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_t;

  typedef struct packed {
    logic [18:0] hp;
    logic        tone;
    logic [8:0]  dur;
    logic        last;
  } step_t;

  function automatic step_t step_lookup(input logic [1:0] eff, input logic [1:0] stp);
    step_t s;
    case ({eff, stp})
      4'b01_00: s = {19'd56818,  1'b1, 9'd80,  1'b0};
      4'b01_01: s = {19'd28409,  1'b1, 9'd80,  1'b1};
      4'b10_00: s = {19'd28409,  1'b1, 9'd60,  1'b0};
      4'b10_01: s = {19'd18939,  1'b1, 9'd120, 1'b1};
      4'b11_00: s = {19'd113636, 1'b1, 9'd200, 1'b0};
      4'b11_01: s = {19'd0,      1'b0, 9'd50,  1'b0};
      4'b11_10: s = {19'd113636, 1'b1, 9'd300, 1'b1};
      default:  s = {19'd0,      1'b0, 9'd1,   1'b1};
    endcase
    return s;
  endfunction

  state_t      state_r, state_n_s;
  logic [1:0]  step_r, step_n_s;
  logic [PW-1:0] presc_r, presc_n_s;
  logic [8:0]  ticks_r, ticks_n_s;
  logic [1:0]  active_r, active_n_s;
  logic [18:0] hp_r, hp_n_s;
  logic        tone_r, tone_n_s;
  logic        busy_r, busy_n_s;
  logic [2:0]  ack_r, ack_n_s;

  step_t       cur_s, nxt_s;
  logic [1:0]  req_id_s;
  logic        step_end_s;
  logic        accept_s;

  // State and output registers
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_r  <= IDLE;
      step_r   <= 2'd0;
      presc_r  <= '0;
      ticks_r  <= 9'd0;
      active_r <= 2'd0;
      hp_r     <= 19'd0;
      tone_r   <= 1'b0;
      busy_r   <= 1'b0;
      ack_r    <= 3'd0;
    end else begin
      state_r  <= state_n_s;
      step_r   <= step_n_s;
      presc_r  <= presc_n_s;
      ticks_r  <= ticks_n_s;
      active_r <= active_n_s;
      hp_r     <= hp_n_s;
      tone_r   <= tone_n_s;
      busy_r   <= busy_n_s;
      ack_r    <= ack_n_s;
    end
  end

  // Request arbitration and step sequencing
  always_comb begin
    cur_s = step_lookup(active_r, step_r);
    if (req[2]) begin
      req_id_s = 2'd3;
    end else if (req[1]) begin
      req_id_s = 2'd2;
    end else if (req[0]) begin
      req_id_s = 2'd1;
    end else begin
      req_id_s = 2'd0;
    end
    step_end_s = (state_r == PLAY) && (presc_r == PW'(TICK_DIV - 1)) &&
                 (ticks_r == cur_s.dur - 9'd1);
    // The end of the last step frees the channel, so any request may start.
    accept_s = (req_id_s != 2'd0) &&
               ((state_r == IDLE) || (req_id_s > active_r) || (step_end_s && cur_s.last));

    state_n_s  = state_r;
    step_n_s   = step_r;
    presc_n_s  = presc_r;
    ticks_n_s  = ticks_r;
    active_n_s = active_r;
    ack_n_s    = 3'd0;
    if (accept_s) begin
      state_n_s  = PLAY;
      step_n_s   = 2'd0;
      presc_n_s  = '0;
      ticks_n_s  = 9'd0;
      active_n_s = req_id_s;
      ack_n_s    = 3'd1 << (req_id_s - 2'd1);
    end else if (state_r == PLAY) begin
      if (step_end_s) begin
        presc_n_s = '0;
        ticks_n_s = 9'd0;
        if (cur_s.last) begin
          state_n_s  = IDLE;
          step_n_s   = 2'd0;
          active_n_s = 2'd0;
        end else begin
          step_n_s = step_r + 2'd1;
        end
      end else if (presc_r == PW'(TICK_DIV - 1)) begin
        presc_n_s = '0;
        ticks_n_s = ticks_r + 9'd1;
      end else begin
        presc_n_s = presc_r + PW'(1);
      end
    end else begin
      state_n_s = IDLE;
    end
  end

  // Next registered output values from the next step
  always_comb begin
    nxt_s = step_lookup(active_n_s, step_n_s);
    if (state_n_s == PLAY) begin
      hp_n_s   = nxt_s.hp;
      tone_n_s = nxt_s.tone;
      busy_n_s = 1'b1;
    end else begin
      hp_n_s   = 19'd0;
      tone_n_s = 1'b0;
      busy_n_s = 1'b0;
    end
  end

  assign half_period = hp_r;
  assign tone_on     = tone_r & ~mute;
  assign busy        = busy_r;
  assign active_id   = active_r;
  assign ack         = ack_r;

endmodule

// File: tb/tb_sfx_scheduler.sv
// Directed bench for sfx_scheduler with TICK_DIV=10 (1 ms step = 10 cycles).
module tb_sfx_scheduler;

  logic        CLOCK_50 = 1'b0;
  logic        reset    = 1'b1;
  logic [2:0]  req      = 3'd0;
  logic        mute     = 1'b0;
  logic [18:0] half_period;
  logic        tone_on;
  logic        busy;
  logic [1:0]  active_id;
  logic [2:0]  ack;

  int tests  = 0;
  int failed = 0;

  sfx_scheduler #(.TICK_DIV(10)) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .req         (req),
    .mute        (mute),
    .half_period (half_period),
    .tone_on     (tone_on),
    .busy        (busy),
    .active_id   (active_id),
    .ack         (ack)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic        rst;
    logic [2:0]  rq;
    int          cyc;
    logic [18:0] hp;
    logic        tone;
    logic        bsy;
    logic [1:0]  id;
    logic [2:0]  ak;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic [2:0] rq, input int cyc,
                              input logic [18:0] hp, input logic tone, input logic bsy,
                              input logic [1:0] id, input logic [2:0] ak);
    vec_t v;
    v.rst = rst; v.rq = rq; v.cyc = cyc; v.hp = hp;
    v.tone = tone; v.bsy = bsy; v.id = id; v.ak = ak;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [18:0] got, input logic [18:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [18:0] hp, input logic tone,
                         input logic bsy, input logic [1:0] id, input logic [2:0] ak);
    chk({tag, ".half_period"}, half_period, hp);
    chk({tag, ".tone_on"}, {18'd0, tone_on}, {18'd0, tone});
    chk({tag, ".busy"}, {18'd0, busy}, {18'd0, bsy});
    chk({tag, ".active_id"}, {17'd0, active_id}, {17'd0, id});
    chk({tag, ".ack"}, {16'd0, ack}, {16'd0, ak});
  endtask

  task automatic adv(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic pulse(input logic [2:0] r);
    req = r;
    adv(1);
    req = 3'd0;
  endtask

  initial begin
    // Reset, jump, death with ignored lower request, reset mid-death, jump.
    vecs.push_back(mk(1'b1, 3'b100, 1,    19'd0,      1'b0, 1'b0, 2'd0, 3'b000));
    vecs.push_back(mk(1'b0, 3'b001, 1,    19'd56818,  1'b1, 1'b1, 2'd1, 3'b001));
    vecs.push_back(mk(1'b0, 3'b000, 799,  19'd56818,  1'b1, 1'b1, 2'd1, 3'b000));
    vecs.push_back(mk(1'b0, 3'b000, 1,    19'd28409,  1'b1, 1'b1, 2'd1, 3'b000));
    vecs.push_back(mk(1'b0, 3'b000, 799,  19'd28409,  1'b1, 1'b1, 2'd1, 3'b000));
    vecs.push_back(mk(1'b0, 3'b000, 1,    19'd0,      1'b0, 1'b0, 2'd0, 3'b000));
    vecs.push_back(mk(1'b0, 3'b111, 1,    19'd113636, 1'b1, 1'b1, 2'd3, 3'b100));
    vecs.push_back(mk(1'b0, 3'b000, 1999, 19'd113636, 1'b1, 1'b1, 2'd3, 3'b000));
    vecs.push_back(mk(1'b0, 3'b000, 1,    19'd0,      1'b0, 1'b1, 2'd3, 3'b000));
    vecs.push_back(mk(1'b0, 3'b000, 499,  19'd0,      1'b0, 1'b1, 2'd3, 3'b000));
    vecs.push_back(mk(1'b0, 3'b000, 1,    19'd113636, 1'b1, 1'b1, 2'd3, 3'b000));
    vecs.push_back(mk(1'b0, 3'b011, 1,    19'd113636, 1'b1, 1'b1, 2'd3, 3'b000));
    vecs.push_back(mk(1'b0, 3'b000, 2998, 19'd113636, 1'b1, 1'b1, 2'd3, 3'b000));
    vecs.push_back(mk(1'b0, 3'b000, 1,    19'd0,      1'b0, 1'b0, 2'd0, 3'b000));
    vecs.push_back(mk(1'b0, 3'b100, 1,    19'd113636, 1'b1, 1'b1, 2'd3, 3'b100));
    vecs.push_back(mk(1'b0, 3'b000, 2000, 19'd0,      1'b0, 1'b1, 2'd3, 3'b000));
    vecs.push_back(mk(1'b1, 3'b000, 1,    19'd0,      1'b0, 1'b0, 2'd0, 3'b000));
    vecs.push_back(mk(1'b0, 3'b001, 1,    19'd56818,  1'b1, 1'b1, 2'd1, 3'b001));
    vecs.push_back(mk(1'b0, 3'b000, 800,  19'd28409,  1'b1, 1'b1, 2'd1, 3'b000));
    vecs.push_back(mk(1'b0, 3'b000, 800,  19'd0,      1'b0, 1'b0, 2'd0, 3'b000));

    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst;
      req   = vecs[i].rq;
      adv(1);
      reset = 1'b0;
      req   = 3'd0;
      adv(vecs[i].cyc - 1);
      chk_all($sformatf("vec%0d", i), vecs[i].hp, vecs[i].tone, vecs[i].bsy,
              vecs[i].id, vecs[i].ak);
    end

    // Score preempts jump at cycle 300 of jump step 0.
    pulse(3'b001);
    chk_all("pre_jump", 19'd56818, 1'b1, 1'b1, 2'd1, 3'b001);
    adv(299);
    pulse(3'b010);
    chk_all("preempt", 19'd28409, 1'b1, 1'b1, 2'd2, 3'b010);
    adv(599);
    chk_all("score_s0_end", 19'd28409, 1'b1, 1'b1, 2'd2, 3'b000);
    adv(1);
    chk_all("score_s1", 19'd18939, 1'b1, 1'b1, 2'd2, 3'b000);
    pulse(3'b001);
    chk_all("low_drop", 19'd18939, 1'b1, 1'b1, 2'd2, 3'b000);

    // Mute gates tone_on without a clock edge and leaves timing alone.
    mute = 1'b1;
    #1;
    chk_all("mute_on", 19'd18939, 1'b0, 1'b1, 2'd2, 3'b000);
    adv(500);
    chk_all("mute_hold", 19'd18939, 1'b0, 1'b1, 2'd2, 3'b000);
    mute = 1'b0;
    #1;
    chk_all("mute_off", 19'd18939, 1'b1, 1'b1, 2'd2, 3'b000);

    // Jump requested in the final score cycle chains straight into PLAY.
    adv(698);
    chk_all("score_last", 19'd18939, 1'b1, 1'b1, 2'd2, 3'b000);
    pulse(3'b001);
    chk_all("chain_jump", 19'd56818, 1'b1, 1'b1, 2'd1, 3'b001);
    adv(1600);
    chk_all("final_idle", 19'd0, 1'b0, 1'b0, 2'd0, 3'b000);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
